// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Groups the EX/MEM-side inputs and MEM/WB-side outputs of the MEM stage.
//   master : the pipeline side (drives instruction fields, observes results/stall)
//   slave  : the MEM stage itself
//   Inputs to the stage : valid_in, memread, memwrite, regwrite_in, memtoreg_in,
//                         alu_res[31:0], wdata[31:0], AW_in[4:0]
//   Outputs of the stage: regwrite, memtoreg, res[31:0], dato[31:0], AW[4:0],
//                         valid_out, stall, mem_err
interface mem_access_stage_if;
  logic        valid_in;
  logic        memread;
  logic        memwrite;
  logic        regwrite_in;
  logic        memtoreg_in;
  logic [31:0] alu_res;
  logic [31:0] wdata;
  logic [4:0]  AW_in;

  logic        regwrite;
  logic        memtoreg;
  logic [31:0] res;
  logic [31:0] dato;
  logic [4:0]  AW;
  logic        valid_out;
  logic        stall;
  logic        mem_err;

  modport master (
    output valid_in, memread, memwrite, regwrite_in, memtoreg_in,
           alu_res, wdata, AW_in,
    input  regwrite, memtoreg, res, dato, AW, valid_out, stall, mem_err
  );

  modport slave (
    input  valid_in, memread, memwrite, regwrite_in, memtoreg_in,
           alu_res, wdata, AW_in,
    output regwrite, memtoreg, res, dato, AW, valid_out, stall, mem_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of a 5-stage MIPS pipeline. Performs word loads/stores on an
//   internal data memory whose access takes WAIT_CYCLES extra cycles, and
//   registers the instruction results into the MEM/WB buffer.
//   Parameters: DEPTH (words, power of 2, >= 2), WAIT_CYCLES (0 = single cycle)
//   Ports: clk, rst_n (async, active low), bus (mem_access_stage_if.slave)
module mem_access_stage #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_access_stage_if.slave    bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               valid_out_q, valid_out_d;
  logic               regwrite_q, regwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic               mem_err_q, mem_err_d;
  logic [31:0]        res_q, res_d;
  logic [31:0]        dato_q, dato_d;
  logic [4:0]         aw_q, aw_d;

  logic [31:0]        mem_q [DEPTH];

  logic               mem_op;
  logic               is_load;
  logic               fault;
  logic               complete;
  logic               stall;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_index;
  logic [31:0]        rdata;

  // A store wins when memread and memwrite are both set.
  assign mem_op    = bus.valid_in & (bus.memread | bus.memwrite);
  assign is_load   = bus.memread & ~bus.memwrite;
  assign fault     = (bus.alu_res[1:0] != 2'b00) || ({1'b0, bus.alu_res} >= ADDR_LIMIT);
  assign mem_index = bus.alu_res[IDX_W+1:2];
  assign rdata     = mem_q[mem_index];

  // Completion happens either immediately (no memory access or zero wait)
  // or on the edge where the BUSY countdown has reached zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && (WAIT_CYCLES != 0)) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          stall   = 1'b1;
        end else begin
          complete = bus.valid_in;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          stall = 1'b1;
        end else begin
          state_d  = IDLE;
          complete = bus.valid_in;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Gated with rst_n so a store presented during reset can never commit.
  assign mem_we = complete & bus.memwrite & ~fault & rst_n;

  // On a bubble, the data fields hold and the control bits drop to 0.
  always_comb begin
    valid_out_d = 1'b0;
    regwrite_d  = 1'b0;
    memtoreg_d  = 1'b0;
    mem_err_d   = 1'b0;
    res_d       = res_q;
    dato_d      = dato_q;
    aw_d        = aw_q;
    if (complete) begin
      valid_out_d = 1'b1;
      regwrite_d  = bus.regwrite_in;
      memtoreg_d  = bus.memtoreg_in;
      res_d       = bus.alu_res;
      aw_d        = bus.AW_in;
      mem_err_d   = mem_op & fault;
      dato_d      = (is_load && !fault) ? rdata : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_out_q <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      mem_err_q   <= 1'b0;
      res_q       <= 32'h0;
      dato_q      <= 32'h0;
      aw_q        <= 5'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_out_q <= valid_out_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      mem_err_q   <= mem_err_d;
      res_q       <= res_d;
      dato_q      <= dato_d;
      aw_q        <= aw_d;
    end
  end

  // Data memory has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_index] <= bus.wdata;
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.regwrite  = regwrite_q;
  assign bus.memtoreg  = memtoreg_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.res       = res_q;
  assign bus.dato      = dato_q;
  assign bus.AW        = aw_q;
  assign bus.stall     = stall;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Drives two instances of the MEM stage with directed and random instructions:
//   dut_a (DEPTH 256, WAIT_CYCLES 2) and dut_b (DEPTH 16, WAIT_CYCLES 0).
//   A behavioural model (word arrays plus last-result registers) gives the
//   expected outputs for every instruction.
module tb_mem_access_stage;

  localparam int DEPTH_A = 256;
  localparam int WAIT_A  = 2;
  localparam int DEPTH_B = 16;
  localparam int WAIT_B  = 0;

  logic clk;
  logic rst_n;

  mem_access_stage_if bus_a ();
  mem_access_stage_if bus_b ();

  mem_access_stage #(.DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  mem_access_stage #(.DEPTH(DEPTH_B), .WAIT_CYCLES(WAIT_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic        valid_out;
    logic        regwrite;
    logic        memtoreg;
    logic        stall;
    logic        mem_err;
    logic [31:0] res;
    logic [31:0] dato;
    logic [4:0]  aw;
  } out_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: index 1 = dut_a, index 0 = dut_b.
  logic [31:0] ref_mem_a [DEPTH_A];
  logic [31:0] ref_mem_b [DEPTH_B];
  logic [31:0] last_res  [2];
  logic [31:0] last_dato [2];
  logic [4:0]  last_aw   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic out_t sample(input int sel);
    out_t o;
    if (sel == 1) begin
      o.valid_out = bus_a.valid_out; o.regwrite = bus_a.regwrite;
      o.memtoreg  = bus_a.memtoreg;  o.stall    = bus_a.stall;
      o.mem_err   = bus_a.mem_err;   o.res      = bus_a.res;
      o.dato      = bus_a.dato;      o.aw       = bus_a.AW;
    end else begin
      o.valid_out = bus_b.valid_out; o.regwrite = bus_b.regwrite;
      o.memtoreg  = bus_b.memtoreg;  o.stall    = bus_b.stall;
      o.mem_err   = bus_b.mem_err;   o.res      = bus_b.res;
      o.dato      = bus_b.dato;      o.aw       = bus_b.AW;
    end
    return o;
  endfunction

  // Presents one instruction on the selected bus; the other bus goes idle.
  task automatic applyStimulus(input int sel, input bit valid, input bit rd,
                               input bit wr, input bit rw_in, input bit m2r,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [4:0] aw);
    if (sel == 1) begin
      bus_a.valid_in = valid; bus_a.memread = rd; bus_a.memwrite = wr;
      bus_a.regwrite_in = rw_in; bus_a.memtoreg_in = m2r;
      bus_a.alu_res = addr; bus_a.wdata = wd; bus_a.AW_in = aw;
      bus_b.valid_in = 1'b0;
    end else begin
      bus_b.valid_in = valid; bus_b.memread = rd; bus_b.memwrite = wr;
      bus_b.regwrite_in = rw_in; bus_b.memtoreg_in = m2r;
      bus_b.alu_res = addr; bus_b.wdata = wd; bus_b.AW_in = aw;
      bus_a.valid_in = 1'b0;
    end
  endtask

  task automatic idleBoth();
    bus_a.valid_in = 1'b0;
    bus_b.valid_in = 1'b0;
  endtask

  // Runs one instruction to completion. Called and returns 1 time unit after
  // a rising edge. Expected values come from the model's word arrays.
  task automatic runOp(input int sel, input bit valid, input bit rd, input bit wr,
                       input bit rw_in, input bit m2r, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] aw, input string tag);
    int   depth;
    int   waits;
    bit   mem_op;
    bit   fault;
    int   idx;
    out_t o;
    logic [31:0] exp_dato;
    depth  = (sel == 1) ? DEPTH_A : DEPTH_B;
    waits  = (sel == 1) ? WAIT_A : WAIT_B;
    mem_op = valid && (rd || wr);
    fault  = (addr % 4 != 0) || (addr >= 32'(4 * depth));
    idx    = int'(addr / 4);

    applyStimulus(sel, valid, rd, wr, rw_in, m2r, addr, wd, aw);
    for (int k = 0; k < (mem_op ? waits : 0); k++) begin
      @(negedge clk);
      o = sample(sel);
      checkOutput({tag, ".stall_hi"}, o.stall, 1);
      @(posedge clk); #1;
      o = sample(sel);
      checkOutput({tag, ".bub_valid"}, o.valid_out, 0);
      checkOutput({tag, ".bub_regwrite"}, o.regwrite, 0);
      checkOutput({tag, ".bub_err"}, o.mem_err, 0);
      checkOutput({tag, ".bub_res"}, o.res, last_res[sel]);
    end
    @(negedge clk);
    o = sample(sel);
    checkOutput({tag, ".stall_lo"}, o.stall, 0);
    @(posedge clk); #1;
    o = sample(sel);

    if (valid) begin
      exp_dato = 32'h0;
      if (rd && !wr && !fault)
        exp_dato = (sel == 1) ? ref_mem_a[idx] : ref_mem_b[idx];
      if (wr && !fault) begin
        if (sel == 1) ref_mem_a[idx] = wd;
        else          ref_mem_b[idx] = wd;
      end
      last_res[sel]  = addr;
      last_aw[sel]   = aw;
      last_dato[sel] = exp_dato;
      checkOutput({tag, ".valid"}, o.valid_out, 1);
      checkOutput({tag, ".regwrite"}, o.regwrite, rw_in);
      checkOutput({tag, ".memtoreg"}, o.memtoreg, m2r);
      checkOutput({tag, ".err"}, o.mem_err, mem_op && fault);
    end else begin
      checkOutput({tag, ".valid"}, o.valid_out, 0);
      checkOutput({tag, ".regwrite"}, o.regwrite, 0);
      checkOutput({tag, ".memtoreg"}, o.memtoreg, 0);
      checkOutput({tag, ".err"}, o.mem_err, 0);
    end
    checkOutput({tag, ".res"}, o.res, last_res[sel]);
    checkOutput({tag, ".aw"}, o.aw, last_aw[sel]);
    checkOutput({tag, ".dato"}, o.dato, last_dato[sel]);
  endtask

  task automatic checkZeroOutputs(input int sel, input string tag);
    out_t o;
    o = sample(sel);
    checkOutput({tag, ".valid"}, o.valid_out, 0);
    checkOutput({tag, ".regwrite"}, o.regwrite, 0);
    checkOutput({tag, ".memtoreg"}, o.memtoreg, 0);
    checkOutput({tag, ".err"}, o.mem_err, 0);
    checkOutput({tag, ".stall"}, o.stall, 0);
    checkOutput({tag, ".res"}, o.res, 0);
    checkOutput({tag, ".dato"}, o.dato, 0);
    checkOutput({tag, ".aw"}, o.aw, 0);
  endtask

  function automatic logic [31:0] randomAddr(input int depth);
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'(4 * $urandom_range(0, depth - 1));
    else if (r == 7) return 32'(4 * $urandom_range(0, depth - 1) + $urandom_range(1, 3));
    else if (r == 8) return 32'(4 * depth + 4 * $urandom_range(0, 100));
    else             return $urandom | 32'h8000_0000;
  endfunction

  task automatic randomPhase(input int sel, input int count, input string tag);
    int kind;
    bit valid;
    for (int n = 0; n < count; n++) begin
      valid = ($urandom_range(0, 9) != 0);
      kind  = $urandom_range(0, 3);
      runOp(sel, valid, (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
            1'($urandom), 1'($urandom), randomAddr((sel == 1) ? DEPTH_A : DEPTH_B),
            $urandom, 5'($urandom), tag);
    end
    idleBoth();
  endtask

  initial begin
    out_t o;
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
    for (int s = 0; s < 2; s++) begin
      last_res[s] = 32'h0; last_dato[s] = 32'h0; last_aw[s] = 5'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkZeroOutputs(1, "rst_a");
    checkZeroOutputs(0, "rst_b");
    rst_n = 1'b1;

    // Give both memories known contents.
    for (int i = 0; i < DEPTH_A; i++)
      runOp(1, 1, 0, 1, 0, 0, 32'(4 * i), $urandom, 5'h0, "init_a");
    for (int i = 0; i < DEPTH_B; i++)
      runOp(0, 1, 0, 1, 0, 0, 32'(4 * i), $urandom, 5'h0, "init_b");
    idleBoth();

    // Reset in the middle of a pending store aborts it.
    runOp(1, 1, 0, 1, 0, 0, 32'h10, 32'h1111_1111, 5'h3, "t1_pre");
    applyStimulus(1, 1, 0, 1, 1, 0, 32'h10, 32'hDEAD_BEEF, 5'h7);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_a.valid_in = 1'b0;
    #1;
    checkZeroOutputs(1, "t1_rst");
    for (int s = 0; s < 2; s++) begin
      last_res[s] = 32'h0; last_dato[s] = 32'h0; last_aw[s] = 5'h0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    runOp(1, 1, 1, 0, 1, 1, 32'h10, 32'h0, 5'h9, "t1_load");
    checkOutput("t1_old_value", bus_a.dato, 32'h1111_1111);

    // Single-cycle R-type on the zero-wait instance.
    runOp(0, 1, 0, 0, 1, 0, 32'h1234, 32'h0, 5'd5, "t2");
    checkOutput("t2_res_const", bus_b.res, 32'h1234);

    // Store then load back-to-back through the wait states.
    runOp(1, 1, 0, 1, 0, 0, 32'h20, 32'hCAFE_F00D, 5'h0, "t3_store");
    runOp(1, 1, 1, 0, 1, 1, 32'h20, 32'h0, 5'd8, "t3_load");
    checkOutput("t3_dato_const", bus_a.dato, 32'hCAFE_F00D);

    // Misaligned load: zero data, one-cycle error pulse.
    runOp(1, 1, 1, 0, 1, 1, 32'h22, 32'h0, 5'd4, "t4_load");
    runOp(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0, "t4_after");

    // Out-of-range store leaves every word untouched.
    runOp(1, 1, 0, 1, 1, 0, 32'(4 * DEPTH_A), 32'h5A5A_5A5A, 5'd2, "t5_store");
    for (int i = 0; i < DEPTH_A; i++)
      runOp(1, 1, 1, 0, 0, 0, 32'(4 * i), 32'h0, 5'h0, "t5_readback");

    // memread and memwrite together behave as a store.
    runOp(1, 1, 1, 1, 0, 0, 32'h8, 32'h55, 5'd1, "t6_both");
    runOp(1, 1, 1, 0, 0, 0, 32'h8, 32'h0, 5'd1, "t6_load");
    checkOutput("t6_dato_const", bus_a.dato, 32'h55);

    // Same-address store/load pairs on the zero-wait instance.
    runOp(0, 1, 0, 1, 0, 0, 32'h3C, 32'h1357_9BDF, 5'h0, "t7_store");
    runOp(0, 1, 1, 0, 1, 1, 32'h3C, 32'h0, 5'd6, "t7_load");
    runOp(0, 1, 1, 0, 1, 1, 32'h40, 32'h0, 5'd6, "t7_oob");
    idleBoth();

    randomPhase(1, 150, "rand_a");
    randomPhase(0, 300, "rand_b");

    @(posedge clk); #1;
    o = sample(1);
    checkOutput("end_stall_a", o.stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
